// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core; fetch and data share one request/ready memory bus.
// Optional macro MIPS_MMIO_PORT_EN maps PortIn/PortOut at 0xFFFF0000/0xFFFF0004.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          NUM_REGS     = 32,
   parameter int          MEM_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic [31:0] ALUResultOut,
   output logic        halted,
   output logic [1:0]  halt_cause
);
   localparam int RW = $clog2(NUM_REGS);
   localparam int WW = $clog2(MEM_WAIT_MAX + 2);
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                          OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                          OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20, FN_SUB = 6'h22,
                          FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, ir_q, a_q, b_q, alu_q, mdr_q, tgt_q;
   logic [31:0]   rf_q [NUM_REGS];
   logic [1:0]    cause_q;
   logic [WW-1:0] wait_q;

   logic [5:0]    op, fn;
   logic [RW-1:0] rs_idx, rt_idx, rd_idx, wr_idx;
   logic [31:0]   sext, zext, alu_d;
   logic          legal, req_act, timeout, mmio_ld, mmio_st;

   assign op     = ir_q[31:26];
   assign fn     = ir_q[5:0];
   assign rs_idx = ir_q[21 +: RW];
   assign rt_idx = ir_q[16 +: RW];
   assign rd_idx = ir_q[11 +: RW];
   assign wr_idx = (op == OP_R) ? rd_idx : rt_idx;
   assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};
   assign zext   = {16'h0000, ir_q[15:0]};

`ifdef MIPS_MMIO_PORT_EN
   logic [31:0] port_q;
   assign mmio_ld = (state_q == MEM) && (op == OP_LW) && (alu_q == 32'hFFFF_0000);
   assign mmio_st = (state_q == MEM) && (op == OP_SW) && (alu_q == 32'hFFFF_0004);
   assign PortOut = port_q;
   always_ff @(posedge clk) begin
      if (!reset)       port_q <= '0;
      else if (mmio_st) port_q <= b_q;
   end
`else
   assign mmio_ld = 1'b0;
   assign mmio_st = 1'b0;
   assign PortOut = '0;
`endif

   // Bus is owned in FETCH and in MEM unless the access hits the local port.
   assign req_act      = (state_q == FETCH) || ((state_q == MEM) && !mmio_ld && !mmio_st);
   assign timeout      = req_act && !mem_ready && (wait_q == WW'(MEM_WAIT_MAX));
   assign mem_req      = req_act && reset;
   assign mem_we       = mem_req && (state_q == MEM) && (op == OP_SW);
   assign mem_addr     = {((state_q == FETCH) ? pc_q[31:2] : alu_q[31:2]), 2'b00};
   assign mem_wdata    = b_q;
   assign ALUResultOut = alu_q;
   assign halted       = (state_q == HALT);
   assign halt_cause   = cause_q;

   always_comb begin
      legal = 1'b0;
      case (op)
         OP_R:    legal = fn inside {FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
         OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      alu_d = '0;
      case (op)
         OP_R: begin
            case (fn)
               FN_ADD:  alu_d = a_q + b_q;
               FN_SUB:  alu_d = a_q - b_q;
               FN_AND:  alu_d = a_q & b_q;
               FN_OR:   alu_d = a_q | b_q;
               FN_SLT:  alu_d = {31'b0, $signed(a_q) < $signed(b_q)};
               FN_SLL:  alu_d = b_q << ir_q[10:6];
               FN_SRL:  alu_d = b_q >> ir_q[10:6];
               default: alu_d = '0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: alu_d = a_q + sext;
         OP_ANDI:               alu_d = a_q & zext;
         OP_ORI:                alu_d = a_q | zext;
         OP_LUI:                alu_d = {ir_q[15:0], 16'h0000};
         OP_BEQ, OP_BNE:        alu_d = a_q - b_q;
         default:               alu_d = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:  if (mem_ready) state_d = DECODE;
                 else if (timeout) state_d = HALT;
         DECODE: state_d = legal ? EXEC : HALT;
         EXEC:   if (op inside {OP_BEQ, OP_BNE, OP_J}) state_d = FETCH;
                 else if (op inside {OP_LW, OP_SW}) state_d = MEM;
                 else state_d = WB;
         MEM:    if (mmio_ld || mmio_st || mem_ready) state_d = (op == OP_SW) ? FETCH : WB;
                 else if (timeout) state_d = HALT;
         WB:     state_d = FETCH;
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         tgt_q   <= '0;
         cause_q <= 2'd0;
         wait_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= (req_act && !mem_ready) ? wait_q + 1'b1 : '0;
         // Only DECODE can halt on a bad opcode; any other entry is a bus timeout.
         if (state_d == HALT && state_q != HALT)
            cause_q <= (state_q == DECODE) ? 2'd1 : 2'd2;
         case (state_q)
            FETCH: if (mem_ready) begin
               ir_q <= mem_rdata;
               pc_q <= pc_q + 32'd4;
            end
            DECODE: begin
               a_q   <= rf_q[rs_idx];
               b_q   <= rf_q[rt_idx];
               tgt_q <= pc_q + {sext[29:0], 2'b00};
            end
            EXEC: begin
               alu_q <= alu_d;
               if ((op == OP_BEQ && a_q == b_q) || (op == OP_BNE && a_q != b_q))
                  pc_q <= tgt_q;
               else if (op == OP_J)
                  pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            end
            MEM: if (mmio_ld) mdr_q <= {24'b0, PortIn};
                 else if (mem_ready) mdr_q <= mem_rdata;
            WB: if (wr_idx != '0) rf_q[wr_idx] <= (op == OP_LW) ? mdr_q : alu_q;
            default: ;
         endcase
      end
   end
endmodule
